// File: rtl/vram_pixel_writer.sv
// Write-side companion to the VRAM display reader: packs an ordered 8-bit pixel
// stream into 36-bit ZBT words and writes one word per free hcount slot.
module vram_pixel_writer #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_data,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        flush,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [35:0] vram_write_data,
    output logic        busy
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [31:0]        pk_data;
    logic [18:0]        pk_addr;
    logic               pk_valid;
    logic               flush_pend;

    logic [50:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               conflict;
    logic               flush_go;
    logic               push;
    logic               pop;
    logic [18:0]        pix_addr;
    logic [1:0]         lane;
    logic [31:0]        merged;
    logic [50:0]        push_word;

    function automatic logic [31:0] lane_write(input logic [31:0] base,
                                               input logic [1:0]  k,
                                               input logic [7:0]  d);
        logic [31:0] r;
        r = base;
        r[8*k +: 8] = d;
        return r;
    endfunction

    always_comb begin
        fifo_full  = (count == FULL_CNT);
        fifo_empty = (count == '0);
        pix_ready  = reset && !fifo_full;
        accept     = pix_valid && pix_ready;
        pix_addr   = {1'b0, pix_y, pix_x[9:2]};
        lane       = pix_x[1:0];
        conflict   = accept && pk_valid && (pix_addr != pk_addr);
        // A fresh or conflicting pixel starts from an all-zero word.
        merged     = lane_write((pk_valid && !conflict) ? pk_data : 32'd0, lane, pix_data);
        // A flush that lands while the FIFO is full is held until there is room.
        flush_go   = (flush || flush_pend) && pk_valid && !accept && !fifo_full;
        push       = 1'b0;
        push_word  = {pk_addr, pk_data};
        if (conflict || flush_go) begin
            push = 1'b1;
        end else if (accept && lane == 2'd3) begin
            push      = 1'b1;
            push_word = {pix_addr, merged};
        end
        pop        = (hcount[1:0] == 2'd1) && !fifo_empty;
        busy       = pk_valid || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pk_valid        <= 1'b0;
            flush_pend      <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            vram_we         <= 1'b0;
            vram_addr       <= '0;
            vram_write_data <= '0;
        end else begin
            if (accept)
                pk_valid <= conflict || (lane != 2'd3);
            else if (flush_go)
                pk_valid <= 1'b0;

            if (flush_go || accept)
                flush_pend <= 1'b0;
            else if (flush && pk_valid)
                flush_pend <= 1'b1;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Write slot: phase 1 decides, the strobe lands in phase 2.
            vram_we <= pop;
            if (pop) begin
                vram_addr       <= fifo_mem[rd_ptr][50:32];
                vram_write_data <= {4'b0000, fifo_mem[rd_ptr][31:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pk_addr <= pix_addr;
            pk_data <= merged;
        end
        if (push)
            fifo_mem[wr_ptr] <= push_word;
    end
endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench for vram_pixel_writer: word-level reference model plus
// directed pixel streams with hand-computed write addresses and data.
`timescale 1ns/1ps
module tb_vram_pixel_writer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] hcount = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_data = '0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        flush = 1'b0;
    logic        vram_we;
    logic [18:0] vram_addr;
    logic [35:0] vram_write_data;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          hc_run = 1'b1;
    logic [18:0] exp_a[$];
    logic [35:0] exp_d[$];
    logic [18:0] log_a[$];
    logic [35:0] log_d[$];
    logic [7:0]  m_lane[4];
    logic [18:0] m_addr = '0;
    bit          m_valid = 1'b0;
    int          n_acc = 0;
    int          acc_at_stall = -1;
    bit          stall_seen = 1'b0;
    longint      cyc = 0;
    longint      last_we = -100;
    int          base;

    vram_pixel_writer #(.FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .hcount(hcount),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .flush(flush),
        .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_write_data(vram_write_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hc_run) hcount = hcount + 11'd1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word is whatever lanes of one address arrived since it opened.
    function automatic void model_push();
        exp_a.push_back(m_addr);
        exp_d.push_back({4'b0000, m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
    endfunction

    function automatic void model_pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] d);
        logic [18:0] a;
        bit          clash;
        a = {1'b0, y, x[9:2]};
        clash = m_valid && (a != m_addr);
        if (clash) model_push();
        if (!m_valid || clash) begin
            for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
            m_addr = a;
        end
        m_lane[x[1:0]] = d;
        if (x[1:0] == 2'd3 && !clash) begin
            model_push();
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
        end
    endfunction

    function automatic void model_flush();
        if (m_valid) begin
            model_push();
            m_valid = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_a.delete();
        exp_d.delete();
        m_valid = 1'b0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset === 1'b1 && vram_we === 1'b1) begin
            chk("we_phase", 64'(hcount[1:0]), 64'd2);
            chk("we_spacing_ge4", 64'(cyc - last_we >= 4), 64'd1);
            last_we = cyc;
            if (exp_a.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                chk("wr_addr", 64'(vram_addr), 64'(exp_a.pop_front()));
                chk("wr_data", 64'(vram_write_data), 64'(exp_d.pop_front()));
            end
            log_a.push_back(vram_addr);
            log_d.push_back(vram_write_data);
        end
    end

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [7:0] d);
        int tries;
        bit done;
        tries = 0;
        done = 1'b0;
        pix_x = x;
        pix_y = y;
        pix_data = d;
        pix_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) begin
                model_pix(x, y, d);
                n_acc++;
                done = 1'b1;
            end else begin
                if (!stall_seen) acc_at_stall = n_acc;
                stall_seen = 1'b1;
                tries++;
                if (tries > 300) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        model_flush();
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_quiet(input bit eb);
        int t;
        t = 0;
        while (exp_a.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_a.size() != 0) chk("drain_timeout", 64'(exp_a.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("busy_idle", 64'(busy), 64'(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic freeze_hc();
        @(negedge clk);
        hc_run = 1'b0;
        hcount = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic resume_hc();
        @(negedge clk);
        hc_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(pix_ready), 64'd0);
        chk("rst_we", 64'(vram_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(vram_addr), 64'd0);
        chk("rst_data", 64'(vram_write_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(pix_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full word, in order
        base = log_a.size();
        for (int i = 0; i < 4; i++) send(10'(i), 10'd5, 8'(8'h11 * (i + 1)));
        wait_quiet(1'b0);
        chk("t1_nwrites", 64'(log_a.size() - base), 64'd1);
        chk("t1_addr", 64'(log_a[base]), 64'h00500);
        chk("t1_data", 64'(log_d[base]), 64'h044332211);

        // Partial word committed by a conflict, then flush
        base = log_a.size();
        send(10'd4, 10'd5, 8'hAA);
        send(10'd5, 10'd5, 8'hBB);
        send(10'd12, 10'd5, 8'hCC);
        wait_quiet(1'b1);
        chk("t2_conf_addr", 64'(log_a[base]), 64'h00501);
        chk("t2_conf_data", 64'(log_d[base]), 64'h00000BBAA);
        do_flush();
        wait_quiet(1'b0);
        chk("t2_nwrites", 64'(log_a.size() - base), 64'd2);
        chk("t2_flush_addr", 64'(log_a[base+1]), 64'h00503);
        chk("t2_flush_data", 64'(log_d[base+1]), 64'h0000000CC);

        // Backpressure: hold the write slot off until the FIFO fills
        freeze_hc();
        base = log_a.size();
        stall_seen = 1'b0;
        n_acc = 0;
        acc_at_stall = -1;
        fork
            begin
                for (int i = 0; i < 24; i++) send(10'(i), 10'd7, 8'(i + 1));
            end
            begin
                repeat (40) @(negedge clk);
                hc_run = 1'b1;
            end
        join
        wait_quiet(1'b0);
        chk("t3_stall_seen", 64'(stall_seen), 64'd1);
        chk("t3_acc_at_stall", 64'(acc_at_stall), 64'd16);
        chk("t3_nwrites", 64'(log_a.size() - base), 64'd6);
        for (int i = 0; i < 6; i++) chk("t3_addr_order", 64'(log_a[base+i]), 64'(19'h00700 + 19'(i)));
        chk("t3_first_data", 64'(log_d[base]), 64'h004030201);
        chk("t3_last_data", 64'(log_d[base+5]), 64'h018171615);

        // Lane overwrite
        base = log_a.size();
        send(10'd8, 10'd9, 8'h01);
        send(10'd8, 10'd9, 8'h02);
        send(10'd9, 10'd9, 8'h03);
        send(10'd10, 10'd9, 8'h04);
        send(10'd11, 10'd9, 8'h05);
        wait_quiet(1'b0);
        chk("t4_nwrites", 64'(log_a.size() - base), 64'd1);
        chk("t4_addr", 64'(log_a[base]), 64'h00902);
        chk("t4_data", 64'(log_d[base]), 64'h005040302);

        // Reset mid-operation: 3 words queued plus 2 pixels packed
        freeze_hc();
        base = log_a.size();
        for (int i = 0; i < 14; i++) send(10'(i), 10'd3, 8'(i));
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready_in_reset", 64'(pix_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_busy_after", 64'(busy), 64'd0);
        chk("t5_we_after", 64'(vram_we), 64'd0);
        resume_hc();
        repeat (30) @(negedge clk);
        chk("t5_no_writes", 64'(log_a.size() - base), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(10'(16 + i), 10'd3, 8'(8'h50 + i));
        wait_quiet(1'b0);
        chk("t5_nwrites", 64'(log_a.size() - base), 64'd1);
        chk("t5_addr", 64'(log_a[base]), 64'h00304);
        chk("t5_data", 64'(log_d[base]), 64'h053525150);

        // Write-slot phase with free-running hcount
        base = log_a.size();
        for (int i = 0; i < 16; i++) send(10'(100 + i), 10'd11, 8'(100 + i));
        wait_quiet(1'b0);
        chk("t6_nwrites", 64'(log_a.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) chk("t6_addr", 64'(log_a[base+i]), 64'(19'h00B19 + 19'(i)));
        chk("t6_first_data", 64'(log_d[base]), 64'h067666564);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
